tlb_op_ctrl: RTL and testbench

- Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) into the MMU as single-cycle pulses and captures the MMU's combinational results into a registered CP0 write-back response.
- Produces the Random register value used by TLBWR.
- Asserts a translation block while the shared data lookup port is taken by TLBP, or while a TLB write is settling, so fetch and memory stages stall instead of using stale translations.
- Sits between the pipeline's CP0/exception stage and the mmu.

---
 rtl/tlb_pkg.sv | 22 ++
 rtl/tlb_random_gen.sv | 34 +++
 rtl/tlb_op_ctrl.sv | 155 +++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and default sizing for the CP0 TLB operation controller.
// Sizing defaults match tlb_defines.vh.
package tlb_pkg;

    localparam int TLB_LINE_DEFAULT  = 32;
    localparam int TLB_WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        TLB_OP_P  = 2'd0,
        TLB_OP_R  = 2'd1,
        TLB_OP_WI = 2'd2,
        TLB_OP_WR = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FENCE,
        ST_RESP
    } tlb_ctrl_state_e;

endpackage

// File: rtl/tlb_random_gen.sv
// CP0 Random register: counts down from TLB_LINE-1 and wraps at Wired or 0.
// Holds its value while a TLBWR is being issued so the write index is stable.
module tlb_random_gen
    import tlb_pkg::*;
#(
    parameter int TLB_LINE  = TLB_LINE_DEFAULT,
    parameter int TLB_WIDTH = TLB_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 wired_we,
    input  logic [TLB_WIDTH-1:0] wired,
    output logic [TLB_WIDTH-1:0] random_q
);

    localparam logic [TLB_WIDTH-1:0] RANDOM_TOP = TLB_WIDTH'(TLB_LINE - 1);

    // A Wired write wins over the freeze; the frozen value has already been used for the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            random_q <= RANDOM_TOP;
        end else if (wired_we) begin
            random_q <= RANDOM_TOP;
        end else if (freeze) begin
            random_q <= random_q;
        end else if ((random_q == wired) || (random_q == '0)) begin
            random_q <= RANDOM_TOP;
        end else begin
            random_q <= random_q - TLB_WIDTH'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR into the MMU as single-cycle pulses and
// returns a registered CP0 write-back response; blocks translation while busy.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLB_LINE     = TLB_LINE_DEFAULT,
    parameter int TLB_WIDTH    = TLB_WIDTH_DEFAULT,
    parameter int FENCE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op_code,
    output logic                 op_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_we_index,
    output logic                 resp_we_entry,
    output logic [31:0]          resp_index,
    output logic [31:0]          resp_entryhi,
    output logic [31:0]          resp_entrylo0,
    output logic [31:0]          resp_entrylo1,
    output logic [31:0]          resp_pagemask,
    output logic                 tlbp,
    output logic                 tlbr,
    output logic                 tlbwi,
    output logic                 tlbwr,
    input  logic [31:0]          mmu_index,
    input  logic [31:0]          mmu_entryhi,
    input  logic [31:0]          mmu_entrylo0,
    input  logic [31:0]          mmu_entrylo1,
    input  logic [31:0]          mmu_pagemask,
    input  logic [TLB_WIDTH-1:0] wired,
    input  logic                 wired_we,
    output logic [31:0]          random_out,
    output logic                 xlate_block
);

    localparam logic [3:0] FENCE_LOAD = 4'(FENCE_CYCLES);

    tlb_ctrl_state_e      state;
    tlb_op_e              op_q;
    tlb_op_e              op_in;
    logic [3:0]           fence_cnt;
    logic [TLB_WIDTH-1:0] random_q;
    logic                 freeze;

    assign op_in      = tlb_op_e'(op_code);
    assign freeze     = (state == ST_ISSUE) && (op_q == TLB_OP_WR);
    assign random_out = {{(32 - TLB_WIDTH){1'b0}}, random_q};

    tlb_random_gen #(
        .TLB_LINE (TLB_LINE),
        .TLB_WIDTH(TLB_WIDTH)
    ) u_random (
        .clk     (clk),
        .rst     (rst),
        .freeze  (freeze),
        .wired_we(wired_we),
        .wired   (wired),
        .random_q(random_q)
    );

    // Pulses default low every cycle; only the IDLE handshake raises one for the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            op_q          <= TLB_OP_P;
            fence_cnt     <= '0;
            op_ready      <= 1'b1;
            resp_valid    <= 1'b0;
            resp_we_index <= 1'b0;
            resp_we_entry <= 1'b0;
            resp_index    <= '0;
            resp_entryhi  <= '0;
            resp_entrylo0 <= '0;
            resp_entrylo1 <= '0;
            resp_pagemask <= '0;
            tlbp          <= 1'b0;
            tlbr          <= 1'b0;
            tlbwi         <= 1'b0;
            tlbwr         <= 1'b0;
            xlate_block   <= 1'b0;
        end else begin
            tlbp  <= 1'b0;
            tlbr  <= 1'b0;
            tlbwi <= 1'b0;
            tlbwr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_q        <= op_in;
                        op_ready    <= 1'b0;
                        xlate_block <= 1'b1;
                        state       <= ST_ISSUE;
                        tlbp        <= (op_in == TLB_OP_P);
                        tlbr        <= (op_in == TLB_OP_R);
                        tlbwi       <= (op_in == TLB_OP_WI);
                        tlbwr       <= (op_in == TLB_OP_WR);
                    end
                end
                ST_ISSUE: begin
                    if ((op_q == TLB_OP_P) || (op_q == TLB_OP_R)) begin
                        resp_index    <= mmu_index;
                        resp_entryhi  <= mmu_entryhi;
                        resp_entrylo0 <= mmu_entrylo0;
                        resp_entrylo1 <= mmu_entrylo1;
                        resp_pagemask <= mmu_pagemask;
                        resp_we_index <= (op_q == TLB_OP_P);
                        resp_we_entry <= (op_q == TLB_OP_R);
                        resp_valid    <= 1'b1;
                        xlate_block   <= 1'b0;
                        state         <= ST_RESP;
                    end else begin
                        resp_we_index <= 1'b0;
                        resp_we_entry <= 1'b0;
                        if (FENCE_CYCLES == 0) begin
                            resp_valid  <= 1'b1;
                            xlate_block <= 1'b0;
                            state       <= ST_RESP;
                        end else begin
                            fence_cnt   <= FENCE_LOAD;
                            xlate_block <= 1'b1;
                            state       <= ST_FENCE;
                        end
                    end
                end
                ST_FENCE: begin
                    // The last fence cycle is the one where the counter steps to zero.
                    if (fence_cnt <= 4'd1) begin
                        fence_cnt   <= '0;
                        resp_valid  <= 1'b1;
                        xlate_block <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        fence_cnt <= fence_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid    <= 1'b0;
                        resp_we_index <= 1'b0;
                        resp_we_entry <= 1'b0;
                        op_ready      <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: a scoreboard queue holds expected responses
// and a monitor compares them as each response appears; timing is checked inline.
module tb_tlb_op_ctrl;

    typedef struct {
        logic        we_index;
        logic        we_entry;
        logic        chk_data;
        logic [31:0] index;
        logic [31:0] entryhi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        logic [31:0] pmask;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_valid0;
    logic [1:0]  op_code, op_code0;
    logic        resp_ready, resp_ready0;
    logic [31:0] mmu_index, mmu_entryhi, mmu_entrylo0, mmu_entrylo1, mmu_pagemask;
    logic [4:0]  wired;
    logic        wired_we;

    logic        op_ready, resp_valid, resp_we_index, resp_we_entry;
    logic [31:0] resp_index, resp_entryhi, resp_entrylo0, resp_entrylo1, resp_pagemask;
    logic        tlbp, tlbr, tlbwi, tlbwr, xlate_block;
    logic [31:0] random_out;

    logic        op_ready0, resp_valid0, resp_we_index0, resp_we_entry0;
    logic [31:0] resp_index0, resp_entryhi0, resp_entrylo00, resp_entrylo10, resp_pagemask0;
    logic        tlbp0, tlbr0, tlbwi0, tlbwr0, xlate_block0;
    logic [31:0] random_out0;

    int    checks   = 0;
    int    failures = 0;
    resp_t sb_q[$];
    logic  prev_valid = 1'b0;
    logic [31:0] exp_rand;

    always #5 clk = ~clk;

    tlb_op_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_we_index(resp_we_index), .resp_we_entry(resp_we_entry),
        .resp_index(resp_index), .resp_entryhi(resp_entryhi), .resp_entrylo0(resp_entrylo0),
        .resp_entrylo1(resp_entrylo1), .resp_pagemask(resp_pagemask),
        .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi), .tlbwr(tlbwr),
        .mmu_index(mmu_index), .mmu_entryhi(mmu_entryhi), .mmu_entrylo0(mmu_entrylo0),
        .mmu_entrylo1(mmu_entrylo1), .mmu_pagemask(mmu_pagemask),
        .wired(wired), .wired_we(wired_we), .random_out(random_out), .xlate_block(xlate_block)
    );

    tlb_op_ctrl #(.FENCE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid0), .op_code(op_code0), .op_ready(op_ready0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_we_index(resp_we_index0), .resp_we_entry(resp_we_entry0),
        .resp_index(resp_index0), .resp_entryhi(resp_entryhi0), .resp_entrylo0(resp_entrylo00),
        .resp_entrylo1(resp_entrylo10), .resp_pagemask(resp_pagemask0),
        .tlbp(tlbp0), .tlbr(tlbr0), .tlbwi(tlbwi0), .tlbwr(tlbwr0),
        .mmu_index(mmu_index), .mmu_entryhi(mmu_entryhi), .mmu_entrylo0(mmu_entrylo0),
        .mmu_entrylo1(mmu_entrylo1), .mmu_pagemask(mmu_pagemask),
        .wired(wired), .wired_we(wired_we), .random_out(random_out0), .xlate_block(xlate_block0)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] code);
        op_code  = code;
        op_valid = 1'b1;
    endtask

    task automatic pushExpect(input logic wi, input logic we, input logic cd);
        resp_t e;
        e.we_index = wi;
        e.we_entry = we;
        e.chk_data = cd;
        e.index    = mmu_index;
        e.entryhi  = mmu_entryhi;
        e.lo0      = mmu_entrylo0;
        e.lo1      = mmu_entrylo1;
        e.pmask    = mmu_pagemask;
        sb_q.push_back(e);
    endtask

    task automatic setMmu(input logic [31:0] i, input logic [31:0] h, input logic [31:0] l0,
                          input logic [31:0] l1, input logic [31:0] pm);
        mmu_index    = i;
        mmu_entryhi  = h;
        mmu_entrylo0 = l0;
        mmu_entrylo1 = l1;
        mmu_pagemask = pm;
    endtask

    // Monitor: compare against the scoreboard on each rising resp_valid of the main DUT.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (resp_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp actual=resp_valid=1 expected=no response");
            end else begin
                e = sb_q.pop_front();
                checkOutput("resp_we_index", {31'b0, resp_we_index}, {31'b0, e.we_index});
                checkOutput("resp_we_entry", {31'b0, resp_we_entry}, {31'b0, e.we_entry});
                if (e.chk_data) begin
                    checkOutput("resp_index", resp_index, e.index);
                    checkOutput("resp_entryhi", resp_entryhi, e.entryhi);
                    checkOutput("resp_entrylo0", resp_entrylo0, e.lo0);
                    checkOutput("resp_entrylo1", resp_entrylo1, e.lo1);
                    checkOutput("resp_pagemask", resp_pagemask, e.pmask);
                end
            end
        end
        prev_valid = resp_valid;
    end

    initial begin
        rst = 1'b0; op_valid = 1'b0; op_code = 2'd0; resp_ready = 1'b1;
        op_valid0 = 1'b0; op_code0 = 2'd0; resp_ready0 = 1'b1;
        wired = 5'd0; wired_we = 1'b0;
        setMmu(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        repeat (2) tick();
        checkOutput("reset_random", random_out, 32'd31);
        checkOutput("reset_op_ready", {31'b0, op_ready}, 32'd1);
        checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("reset_xlate", {31'b0, xlate_block}, 32'd0);
        checkOutput("reset_pulses", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'd0);
        checkOutput("reset_resp_index", resp_index, 32'd0);
        rst = 1'b1;
        wired = 5'd8;

        // Random walk with wired=8: 30 down to 8, then wrap to 31
        exp_rand = 32'd31;
        for (int i = 0; i < 28; i++) begin
            tick();
            exp_rand = (exp_rand == 32'd8 || exp_rand == 32'd0) ? 32'd31 : exp_rand - 32'd1;
            checkOutput("random_walk", random_out, exp_rand);
        end

        // TLBP
        checkOutput("tlbp_idle_ready", {31'b0, op_ready}, 32'd1);
        setMmu(32'h0000_0005, 32'hAAAA_0000, 32'h0000_0101, 32'h0000_0202, 32'h0000_1800);
        pushExpect(1'b1, 1'b0, 1'b1);
        applyStimulus(2'd0);
        tick();
        op_valid = 1'b0;
        checkOutput("tlbp_pulse", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'b1000);
        checkOutput("tlbp_xlate_issue", {31'b0, xlate_block}, 32'd1);
        checkOutput("tlbp_op_ready_issue", {31'b0, op_ready}, 32'd0);
        checkOutput("tlbp_resp_early", {31'b0, resp_valid}, 32'd0);
        tick();
        setMmu(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        checkOutput("tlbp_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("tlbp_pulse_gone", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'd0);
        checkOutput("tlbp_xlate_resp", {31'b0, xlate_block}, 32'd0);
        tick();
        checkOutput("tlbp_back_idle", {30'b0, op_ready, resp_valid}, 32'b10);

        // TLBR with a held response
        setMmu(32'h8000_0000, 32'h8000_0012, 32'h0000_1047, 32'h0000_2087, 32'h0000_6000);
        pushExpect(1'b0, 1'b1, 1'b1);
        resp_ready = 1'b0;
        applyStimulus(2'd1);
        tick();
        op_valid = 1'b0;
        checkOutput("tlbr_pulse", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'b0100);
        tick();
        setMmu(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        checkOutput("tlbr_resp_valid", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("tlbr_hold_valid", {31'b0, resp_valid}, 32'd1);
            checkOutput("tlbr_hold_op_ready", {31'b0, op_ready}, 32'd0);
            checkOutput("tlbr_hold_entryhi", resp_entryhi, 32'h8000_0012);
            checkOutput("tlbr_hold_entrylo0", resp_entrylo0, 32'h0000_1047);
            checkOutput("tlbr_hold_we_entry", {31'b0, resp_we_entry}, 32'd1);
        end
        resp_ready = 1'b1;
        tick();
        checkOutput("tlbr_back_idle", {30'b0, op_ready, resp_valid}, 32'b10);

        // TLBWR with Random resynchronised to 31, then 17 in the ISSUE cycle
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        checkOutput("wired_we_reload", random_out, 32'd31);
        repeat (13) tick();
        checkOutput("tlbwr_pre_random", random_out, 32'd18);
        pushExpect(1'b0, 1'b0, 1'b0);
        applyStimulus(2'd3);
        tick();
        op_valid = 1'b0;
        checkOutput("tlbwr_pulse", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'b0001);
        checkOutput("tlbwr_random_issue", random_out, 32'd17);
        checkOutput("tlbwr_xlate_issue", {31'b0, xlate_block}, 32'd1);
        tick();
        checkOutput("tlbwr_random_frozen", random_out, 32'd17);
        checkOutput("tlbwr_xlate_fence1", {31'b0, xlate_block}, 32'd1);
        checkOutput("tlbwr_no_pulse_fence", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'd0);
        checkOutput("tlbwr_resp_early", {31'b0, resp_valid}, 32'd0);
        tick();
        checkOutput("tlbwr_random_resume", random_out, 32'd16);
        checkOutput("tlbwr_xlate_fence2", {31'b0, xlate_block}, 32'd1);
        checkOutput("tlbwr_resp_early2", {31'b0, resp_valid}, 32'd0);
        tick();
        checkOutput("tlbwr_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("tlbwr_xlate_resp", {31'b0, xlate_block}, 32'd0);
        tick();

        // FENCE_CYCLES=0 instance: TLBWI responds the cycle after ISSUE
        op_code0 = 2'd2;
        op_valid0 = 1'b1;
        tick();
        op_valid0 = 1'b0;
        checkOutput("f0_tlbwi_pulse", {28'b0, tlbp0, tlbr0, tlbwi0, tlbwr0}, 32'b0010);
        checkOutput("f0_xlate_issue", {31'b0, xlate_block0}, 32'd1);
        checkOutput("f0_resp_early", {31'b0, resp_valid0}, 32'd0);
        tick();
        checkOutput("f0_resp_valid", {31'b0, resp_valid0}, 32'd1);
        checkOutput("f0_xlate_resp", {31'b0, xlate_block0}, 32'd0);
        checkOutput("f0_resp_we", {30'b0, resp_we_index0, resp_we_entry0}, 32'd0);
        tick();
        checkOutput("f0_back_idle", {30'b0, op_ready0, resp_valid0}, 32'b10);

        // FENCE_CYCLES=0 instance: wired_we during TLBWR ISSUE
        op_code0 = 2'd3;
        op_valid0 = 1'b1;
        tick();
        op_valid0 = 1'b0;
        checkOutput("f0_tlbwr_pulse", {28'b0, tlbp0, tlbr0, tlbwi0, tlbwr0}, 32'b0001);
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        checkOutput("f0_wired_we_random", random_out0, 32'd31);
        checkOutput("f0_tlbwr_resp", {31'b0, resp_valid0}, 32'd1);
        tick();
        checkOutput("f0_random_after", random_out0, 32'd30);
        checkOutput("main_random_after", random_out, 32'd30);

        // Reset during FENCE aborts the write
        applyStimulus(2'd2);
        tick();
        op_valid = 1'b0;
        checkOutput("abort_pulse", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'b0010);
        tick();
        checkOutput("abort_in_fence", {31'b0, xlate_block}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("abort_xlate", {31'b0, xlate_block}, 32'd0);
        checkOutput("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("abort_op_ready", {31'b0, op_ready}, 32'd1);
        checkOutput("abort_random", random_out, 32'd31);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        end

        // TLBP after the abort completes normally
        setMmu(32'h0000_001F, 32'h0040_2000, 32'h0000_0303, 32'h0000_0404, 32'h0000_0000);
        pushExpect(1'b1, 1'b0, 1'b1);
        applyStimulus(2'd0);
        tick();
        op_valid = 1'b0;
        checkOutput("post_tlbp_pulse", {28'b0, tlbp, tlbr, tlbwi, tlbwr}, 32'b1000);
        tick();
        checkOutput("post_tlbp_resp", {31'b0, resp_valid}, 32'd1);
        repeat (3) tick();

        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
